// File: rtl/motion_driver_pkg.sv
// Shared encodings for the navigation interface between the decision block and motion_driver.
package motion_driver_pkg;

    typedef enum logic [1:0] {
        NavWaiting = 2'b00,
        NavMoving  = 2'b01,
        NavTurning = 2'b10,
        NavCooling = 2'b11
    } nav_state_e;

    typedef enum logic [3:0] {
        MoveStop    = 4'b0000,
        MoveForward = 4'b0001,
        MoveLeft    = 4'b0100,
        MoveRight   = 4'b1000
    } move_e;

    localparam logic [1:0] AutoMode = 2'b01;

    typedef enum logic [1:0] {
        StOff,
        StIdle,
        StDrive,
        StGap
    } drv_state_e;

    function automatic logic is_legal_move(input logic [3:0] code);
        logic legal;
        case (code)
            MoveStop, MoveForward, MoveLeft, MoveRight: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/motion_driver_deadtime_counter.sv
// Saturating dead-time counter; done flags the last all-off cycle of a gap.
module motion_driver_deadtime_counter #(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned CNT_W       = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(DEAD_CYCLES - 1));

endmodule

// File: rtl/motion_driver.sv
// Registers nav commands from the decision block and drives the one-hot motor/steer lines
// with an enforced all-off dead-time between opposing commands.
module motion_driver
    import motion_driver_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [1:0] next_state,
    input  logic [3:0] next_moving_state,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       move_forward_signal,
    output logic       turn_left_signal,
    output logic       turn_right_signal,
    output logic       cmd_fault
);

    logic       enabled;
    logic [1:0] state_q, state_d;
    logic [3:0] move_q, move_d;
    logic [3:0] active_q, active_d;
    logic       fault_q, fault_d;
    drv_state_e fsm_q, fsm_d;
    logic       cnt_clr, cnt_en, cnt_done;

    assign enabled = power && (global_state == AutoMode);

    always_comb begin
        state_d  = state_q;
        move_d   = move_q;
        active_d = active_q;
        fault_d  = fault_q;
        fsm_d    = fsm_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        if (!enabled) begin
            // Disable overrides any FSM activity this cycle.
            state_d  = NavWaiting;
            move_d   = MoveStop;
            active_d = MoveStop;
            fault_d  = 1'b0;
            fsm_d    = StOff;
            cnt_clr  = 1'b1;
        end else begin
            state_d = next_state;
            if (is_legal_move(next_moving_state)) begin
                move_d = next_moving_state;
            end else begin
                move_d  = MoveStop;
                fault_d = 1'b1;
            end

            case (fsm_q)
                StOff: begin
                    active_d = MoveStop;
                    fsm_d    = StIdle;
                end
                StIdle: begin
                    if (move_q != MoveStop) begin
                        active_d = move_q;
                        fsm_d    = StDrive;
                    end
                end
                StDrive: begin
                    if (move_q == MoveStop) begin
                        active_d = MoveStop;
                        fsm_d    = StIdle;
                    end else if (move_q != active_q) begin
                        active_d = MoveStop;
                        cnt_clr  = 1'b1;
                        fsm_d    = StGap;
                    end
                end
                StGap: begin
                    // The request present at gap end wins; changes mid-gap don't restart it.
                    if (move_q == MoveStop) begin
                        cnt_clr = 1'b1;
                        fsm_d   = StIdle;
                    end else if (cnt_done) begin
                        active_d = move_q;
                        fsm_d    = StDrive;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    active_d = MoveStop;
                    fsm_d    = StOff;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= NavWaiting;
            move_q   <= MoveStop;
            active_q <= MoveStop;
            fault_q  <= 1'b0;
            fsm_q    <= StOff;
        end else begin
            state_q  <= state_d;
            move_q   <= move_d;
            active_q <= active_d;
            fault_q  <= fault_d;
            fsm_q    <= fsm_d;
        end
    end

    motion_driver_deadtime_counter #(
        .DEAD_CYCLES(DEAD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deadtime_counter (
        .clk_i (sys_clk),
        .rst_ni(rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .done_o(cnt_done)
    );

    always_comb begin
        move_forward_signal = 1'b0;
        turn_left_signal    = 1'b0;
        turn_right_signal   = 1'b0;
        case (active_q)
            MoveForward: move_forward_signal = 1'b1;
            MoveLeft:    turn_left_signal    = 1'b1;
            MoveRight:   turn_right_signal   = 1'b1;
            default:     ;
        endcase
    end

    assign state        = state_q;
    assign moving_state = move_q;
    assign cmd_fault    = fault_q;

endmodule
